// File: rtl/traffic_lights_gen.sv
// Single-approach traffic-light controller with parametrised timing,
// runtime-programmable durations, blink modes and state readback.
module traffic_lights_gen #(
    parameter int CLK_PER_MS        = 2,
    parameter int CNT_W             = 32,
    parameter int DEF_RED_MS        = 100,
    parameter int DEF_YELLOW_MS     = 10,
    parameter int DEF_GREEN_MS      = 100,
    parameter int RED_YEL_MS        = 50,
    parameter int GREEN_BLINK_MS    = 50,
    parameter int DEF_BLINK_HALF_MS = 5
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        cmd_valid_i,
    input  logic [2:0]  cmd_type_i,
    input  logic [15:0] cmd_data_i,
    output logic        red_o,
    output logic        yellow_o,
    output logic        green_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        RED          = 3'd0,
        RED_YEL      = 3'd1,
        GREEN        = 3'd2,
        GREEN_BLINK  = 3'd3,
        YELLOW       = 3'd4,
        YELLOW_BLINK = 3'd5,
        OFF          = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RED_DEF = CNT_W'(DEF_RED_MS * CLK_PER_MS);
    localparam logic [CNT_W-1:0] YEL_DEF = CNT_W'(DEF_YELLOW_MS * CLK_PER_MS);
    localparam logic [CNT_W-1:0] GRN_DEF = CNT_W'(DEF_GREEN_MS * CLK_PER_MS);
    localparam logic [CNT_W-1:0] BLK_DEF = CNT_W'(DEF_BLINK_HALF_MS * CLK_PER_MS);
    localparam logic [CNT_W-1:0] RY_T    = CNT_W'(RED_YEL_MS * CLK_PER_MS);
    localparam logic [CNT_W-1:0] GB_T    = CNT_W'(GREEN_BLINK_MS * CLK_PER_MS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // A zero-millisecond request is clamped to 1 ms so no state can stall.
    function automatic logic [CNT_W-1:0] to_cycles(input logic [15:0] ms);
        logic [CNT_W-1:0] v;
        v = (ms == 16'd0) ? ONE : CNT_W'(ms);
        return v * CNT_W'(CLK_PER_MS);
    endfunction

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] dur_nxt;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] half;
    logic             phase;
    logic [CNT_W-1:0] red_t;
    logic [CNT_W-1:0] yel_t;
    logic [CNT_W-1:0] grn_t;
    logic [CNT_W-1:0] blk_t;
    logic             timed;
    logic             blinking;
    logic             expire;

    always_comb begin
        nxt      = state;
        timed    = (state == RED) || (state == RED_YEL) || (state == GREEN) ||
                   (state == GREEN_BLINK) || (state == YELLOW);
        blinking = (state == GREEN_BLINK) || (state == YELLOW_BLINK);
        expire   = timed && (cnt == dur - ONE);
        if (expire) begin
            case (state)
                RED:         nxt = RED_YEL;
                RED_YEL:     nxt = GREEN;
                GREEN:       nxt = GREEN_BLINK;
                GREEN_BLINK: nxt = YELLOW;
                YELLOW:      nxt = RED;
                default:     nxt = state;
            endcase
        end
        // Mode commands override a coincident expiry.
        if (cmd_valid_i) begin
            case (cmd_type_i)
                3'd0: if (state == OFF || state == YELLOW_BLINK) nxt = RED;
                3'd1: nxt = OFF;
                3'd2: if (state != YELLOW_BLINK) nxt = YELLOW_BLINK;
                default: ;
            endcase
        end
    end

    always_comb begin
        dur_nxt = '0;
        case (nxt)
            RED:         dur_nxt = red_t;
            RED_YEL:     dur_nxt = RY_T;
            GREEN:       dur_nxt = grn_t;
            GREEN_BLINK: dur_nxt = GB_T;
            YELLOW:      dur_nxt = yel_t;
            default:     dur_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= RED;
            cnt   <= '0;
            dur   <= RED_DEF;
            bcnt  <= '0;
            half  <= BLK_DEF;
            phase <= 1'b1;
            red_t <= RED_DEF;
            yel_t <= YEL_DEF;
            grn_t <= GRN_DEF;
            blk_t <= BLK_DEF;
        end else begin
            if (cmd_valid_i) begin
                case (cmd_type_i)
                    3'd3: grn_t <= to_cycles(cmd_data_i);
                    3'd4: red_t <= to_cycles(cmd_data_i);
                    3'd5: yel_t <= to_cycles(cmd_data_i);
                    3'd6: blk_t <= to_cycles(cmd_data_i);
                    default: ;
                endcase
            end
            state <= nxt;
            // Durations and half-period are snapshotted on state entry.
            if (nxt != state) begin
                cnt   <= '0;
                dur   <= dur_nxt;
                bcnt  <= '0;
                phase <= 1'b1;
                half  <= blk_t;
            end else begin
                if (timed) cnt <= cnt + ONE;
                if (blinking) begin
                    if (bcnt == half - ONE) begin
                        bcnt  <= '0;
                        phase <= ~phase;
                    end else begin
                        bcnt <= bcnt + ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        red_o    = 1'b0;
        yellow_o = 1'b0;
        green_o  = 1'b0;
        case (state)
            RED:          red_o = 1'b1;
            RED_YEL: begin
                red_o    = 1'b1;
                yellow_o = 1'b1;
            end
            GREEN:        green_o  = 1'b1;
            GREEN_BLINK:  green_o  = phase;
            YELLOW:       yellow_o = 1'b1;
            YELLOW_BLINK: yellow_o = phase;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_lights_gen.sv
// Directed bench for traffic_lights_gen: command table plus timed
// sequences for durations, blink phase and expiry/command races.
module tb_traffic_lights_gen;

    logic        clk = 1'b0;
    logic        srst;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [15:0] cmd_data;
    logic        red;
    logic        yellow;
    logic        green;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    traffic_lights_gen dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .cmd_valid_i (cmd_valid),
        .cmd_type_i  (cmd_type),
        .cmd_data_i  (cmd_data),
        .red_o       (red),
        .yellow_o    (yellow),
        .green_o     (green),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  t;
        logic [15:0] d;
        logic [2:0]  s;
        logic [2:0]  rgy;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] t, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_type  = 3'd0;
        cmd_data  = 16'd0;
    endtask

    task automatic lamps(input string nm, input logic [2:0] s,
                         input logic [2:0] ryg);
        chk({nm, "_state"}, 32'(state), 32'(s));
        chk({nm, "_lamps"}, 32'({red, yellow, green}), 32'(ryg));
    endtask

    // Cycles until state_o changes; bounded so a stuck DUT still finishes.
    task automatic dur(input string nm, input logic [2:0] s, input int exp);
        logic [2:0] cur;
        int n;
        chk({nm, "_state"}, 32'(state), 32'(s));
        cur = state;
        n = 0;
        do begin
            tick();
            n++;
        end while (state == cur && n < 2000);
        chk(nm, n, exp);
    endtask

    task automatic gb_pattern(input string nm, input int h);
        for (int i = 0; i < 100; i++) begin
            chk({nm, "_st"}, 32'(state), 32'd3);
            chk({nm, "_g"}, 32'(green), 32'(((i / h) % 2) == 0));
            tick();
        end
        chk({nm, "_end"}, 32'(state), 32'd4);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 3'd1, 16'd0, 3'd6, 3'b000};
        tbl[1]  = '{1'b1, 3'd7, 16'd9, 3'd6, 3'b000};
        tbl[2]  = '{1'b0, 3'd0, 16'd0, 3'd6, 3'b000};
        tbl[3]  = '{1'b1, 3'd0, 16'd0, 3'd0, 3'b100};
        tbl[4]  = '{1'b1, 3'd0, 16'd0, 3'd0, 3'b100};
        tbl[5]  = '{1'b1, 3'd2, 16'd0, 3'd5, 3'b010};
        tbl[6]  = '{1'b1, 3'd2, 16'd0, 3'd5, 3'b010};
        tbl[7]  = '{1'b1, 3'd5, 16'd0, 3'd5, 3'b010};
        tbl[8]  = '{1'b1, 3'd0, 16'd0, 3'd0, 3'b100};
        tbl[9]  = '{1'b1, 3'd2, 16'd0, 3'd5, 3'b010};
        tbl[10] = '{1'b1, 3'd1, 16'd0, 3'd6, 3'b000};
        tbl[11] = '{1'b0, 3'd3, 16'd0, 3'd6, 3'b000};

        srst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 3'd0;
        cmd_data  = 16'd0;
        do_reset();
        lamps("reset", 3'd0, 3'b100);

        for (int i = 0; i < 12; i++) begin
            cmd_valid = tbl[i].v;
            cmd_type  = tbl[i].t;
            cmd_data  = tbl[i].d;
            tick();
            lamps($sformatf("vec%0d", i), tbl[i].s, tbl[i].rgy);
        end
        cmd_valid = 1'b0;

        // Default cycle
        do_reset();
        dur("def_red", 3'd0, 200);
        lamps("def_ry", 3'd1, 3'b110);
        dur("def_ry", 3'd1, 100);
        lamps("def_grn", 3'd2, 3'b001);
        dur("def_grn", 3'd2, 200);
        gb_pattern("def_gb", 10);
        lamps("def_yel", 3'd4, 3'b010);
        dur("def_yel", 3'd4, 20);
        lamps("def_red2", 3'd0, 3'b100);

        // Red write mid-GREEN
        dur("r_red", 3'd0, 200);
        dur("r_ry", 3'd1, 100);
        repeat (50) tick();
        issue(3'd4, 16'd3);
        dur("r_grn_rest", 3'd2, 149);
        dur("r_gb", 3'd3, 100);
        dur("r_yel", 3'd4, 20);
        dur("r_red6", 3'd0, 6);
        issue(3'd4, 16'd0);
        dur("r_ry_rest", 3'd1, 99);
        dur("r_grn", 3'd2, 200);
        dur("r_gb2", 3'd3, 100);
        dur("r_yel2", 3'd4, 20);
        dur("r_red2", 3'd0, 2);

        // Yellow blink from GREEN, repeated cmd 2 keeps phase
        dur("yb_ry", 3'd1, 100);
        repeat (5) tick();
        issue(3'd2, 16'd0);
        for (int i = 0; i < 30; i++) begin
            lamps($sformatf("yb%0d", i), 3'd5,
                  {1'b0, (((i / 10) % 2) == 0), 1'b0});
            if (i == 4) issue(3'd2, 16'd0);
            else tick();
        end
        issue(3'd4, 16'd3);
        issue(3'd0, 16'd0);
        dur("yb_red", 3'd0, 6);

        // OFF from GREEN_BLINK; cmd 0 only acts outside the normal cycle
        dur("off_ry", 3'd1, 100);
        dur("off_grn", 3'd2, 200);
        repeat (3) tick();
        issue(3'd1, 16'd0);
        lamps("off", 3'd6, 3'b000);
        issue(3'd0, 16'd0);
        dur("off_red", 3'd0, 6);
        issue(3'd0, 16'd0);
        dur("nc_ry_rest", 3'd1, 99);

        // Short half-period; cmd 7 is inert
        issue(3'd7, 16'hFFFF);
        dur("c7_grn_rest", 3'd2, 199);
        issue(3'd6, 16'd1);
        issue(3'd2, 16'd0);
        for (int i = 0; i < 12; i++) begin
            lamps($sformatf("h2_%0d", i), 3'd5,
                  {1'b0, (((i / 2) % 2) == 0), 1'b0});
            if (i == 3) issue(3'd7, 16'h1234);
            else tick();
        end

        // cmd 2 on the last YELLOW cycle beats the expiry
        issue(3'd0, 16'd0);
        dur("x_red", 3'd0, 6);
        dur("x_ry", 3'd1, 100);
        dur("x_grn", 3'd2, 200);
        gb_pattern("x_gb", 2);
        repeat (19) tick();
        chk("x_last_yel", 32'(state), 32'd4);
        issue(3'd2, 16'd0);
        lamps("x_race", 3'd5, 3'b010);

        // Reset mid-blink restores defaults
        repeat (3) tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        lamps("mid_rst", 3'd0, 3'b100);
        dur("rst_red", 3'd0, 200);
        dur("rst_ry", 3'd1, 100);
        dur("rst_grn", 3'd2, 200);
        gb_pattern("rst_gb", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
